// File: rtl/hyperbus_delay_ctrl.sv
// HyperBus delay-line tap controller: gates the PHY clock, swaps the tap code, waits for settling.
// Optional timeout on PHY idle handshake enabled by defining HYPERBUS_DELAY_TIMEOUT_EN.
module hyperbus_delay_ctrl #(
    parameter int unsigned CODE_W         = 3,
    parameter int unsigned RESET_CODE     = 0,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [CODE_W-1:0] req_code_i,
    output logic              req_ready_o,
    input  logic              phy_idle_i,
    output logic              gate_o,
    output logic [31:0]       delay_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_APPLY  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [CODE_W-1:0] L_RESET_CODE  = CODE_W'(RESET_CODE);
    localparam logic [7:0]        L_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code_req;
    logic [CODE_W-1:0] r_delay;
    logic [7:0]        r_settle_cnt;
    logic              w_accept;
    logic              w_timeout;

    assign w_accept = req_valid_i && (r_state == ST_IDLE);
    assign delay_o  = {{(32-CODE_W){1'b0}}, r_delay};

`ifdef HYPERBUS_DELAY_TIMEOUT_EN
    localparam logic [15:0] L_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_err;

    assign w_timeout = (r_state == ST_GATE) && !phy_idle_i && (r_to_cnt == L_TO_LAST);
    assign err_o     = r_err;

    // GATE dwell counter and one-cycle timeout pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state != ST_GATE) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (req_code_i == r_delay) ? ST_DONE : ST_GATE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (phy_idle_i) begin
                    w_state_nxt = ST_APPLY;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GATE;
                end
            end
            ST_APPLY:  w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (r_settle_cnt == 8'd0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        gate_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            ST_GATE, ST_APPLY, ST_SETTLE: gate_o = 1'b1;
            ST_DONE: done_o = 1'b1;
            default: begin
                req_ready_o = 1'b0;
                busy_o      = 1'b1;
            end
        endcase
    end

    // Request latch, tap code update (only out of APPLY) and settle countdown
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_code_req   <= L_RESET_CODE;
            r_delay      <= L_RESET_CODE;
            r_settle_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_code_req <= req_code_i;
            end else begin
                r_code_req <= r_code_req;
            end
            if (r_state == ST_APPLY) begin
                r_delay      <= r_code_req;
                r_settle_cnt <= L_SETTLE_LOAD;
            end else if ((r_state == ST_SETTLE) && (r_settle_cnt != 8'd0)) begin
                r_settle_cnt <= r_settle_cnt - 8'd1;
            end else begin
                r_settle_cnt <= r_settle_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Directed self-checking bench for hyperbus_delay_ctrl with a completion scoreboard.
module tb_hyperbus_delay_ctrl;

    localparam int CW = 3;
    localparam int S  = 4;
    localparam int TO = 8;

    typedef struct {
        int cyc;
        int code;
    } ev_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic [CW-1:0] req_code_i;
    logic          req_ready_o;
    logic          phy_idle_i;
    logic          gate_o;
    logic [31:0]   delay_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    ev_t  done_q[$];
    int   err_q[$];
    ev_t  mon_ev;
    int   mon_err;

    hyperbus_delay_ctrl #(
        .CODE_W(CW), .RESET_CODE(0), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_code_i(req_code_i),
        .req_ready_o(req_ready_o), .phy_idle_i(phy_idle_i), .gate_o(gate_o),
        .delay_o(delay_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [CW-1:0] code, output int acc);
        chk("ready_before_req", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_code_i  = code;
        acc         = cyc;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o !== 1'b0 && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        chk("idle_wait", {31'd0, busy_o}, 32'd0);
    endtask

    // Scoreboard: pop expected completions / aborts as the DUT reports them
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_ev = done_q.pop_front();
                chk("done_cycle", cyc, mon_ev.cyc);
                chk("done_delay", delay_o, mon_ev.code);
                chk("done_gate", {31'd0, gate_o}, 32'd0);
            end
        end
        if (err_o === 1'b1) begin
            if (err_q.size() == 0) begin
                chk("unexpected_err", 32'd1, 32'd0);
            end else begin
                mon_err = err_q.pop_front();
                chk("err_cycle", cyc, mon_err);
                chk("err_gate", {31'd0, gate_o}, 32'd0);
            end
        end
    end

    initial begin
        int n;
        int m;
        int gate_cnt;
        int first_chg;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_code_i  = '0;
        phy_idle_i  = 1'b1;

        // Reset
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_delay", delay_o, 32'd0);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_gate",  {31'd0, gate_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_err",   {31'd0, err_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Normal update 0 -> 5
        send(3'd5, n);
        done_q.push_back('{cyc: n + 3 + S, code: 5});
        gate_cnt  = 0;
        first_chg = -1;
        for (int i = 0; i < 10; i++) begin
            if (gate_o === 1'b1) gate_cnt++;
            if (first_chg < 0 && delay_o === 32'd5) first_chg = cyc;
            @(negedge clk_i);
        end
        chk("norm_gate_cycles", gate_cnt, 32'd6);
        chk("norm_delay_edge", first_chg, n + 3);

        // Same code
        send(3'd5, n);
        done_q.push_back('{cyc: n + 1, code: 5});
        chk("same_gate", {31'd0, gate_o}, 32'd0);
        @(negedge clk_i);
        chk("same_delay", delay_o, 32'd5);
        chk("same_busy", {31'd0, busy_o}, 32'd0);

        // Late idle plus ignored mid-flight request
        phy_idle_i = 1'b0;
        send(3'd3, n);
        done_q.push_back('{cyc: n + 12 + S, code: 3});
        repeat (4) @(negedge clk_i);
        req_valid_i = 1'b1;
        req_code_i  = 3'd7;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("late_hold_delay", delay_o, 32'd5);
        chk("late_busy", {31'd0, busy_o}, 32'd1);
        repeat (4) @(negedge clk_i);
        phy_idle_i = 1'b1;
        @(negedge clk_i);
        chk("late_apply_delay", delay_o, 32'd5);
        @(negedge clk_i);
        chk("late_settle_delay", delay_o, 32'd3);
        wait_idle(20);
        repeat (3) @(negedge clk_i);
        chk("late_final_delay", delay_o, 32'd3);

        // PHY never idles
        phy_idle_i = 1'b0;
        send(3'd6, n);
`ifdef HYPERBUS_DELAY_TIMEOUT_EN
        err_q.push_back(n + 1 + TO);
        wait_idle(30);
        repeat (3) @(negedge clk_i);
        chk("to_delay", delay_o, 32'd3);
        chk("to_ready", {31'd0, req_ready_o}, 32'd1);
        chk("to_err_seen", err_q.size(), 32'd0);
        phy_idle_i = 1'b1;
`else
        repeat (1000) @(negedge clk_i);
        chk("wait_gate", {31'd0, gate_o}, 32'd1);
        chk("wait_busy", {31'd0, busy_o}, 32'd1);
        chk("wait_delay", delay_o, 32'd3);
        chk("wait_err", {31'd0, err_o}, 32'd0);
        phy_idle_i = 1'b1;
        m = cyc;
        done_q.push_back('{cyc: m + 2 + S, code: 6});
        wait_idle(20);
        chk("wait_final_delay", delay_o, 32'd6);
`endif
        @(negedge clk_i);

        // Reset in the second SETTLE cycle
        send(3'd2, n);
        repeat (3) @(negedge clk_i);
        chk("mid_settle_gate", {31'd0, gate_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_delay", delay_o, 32'd0);
        chk("mid_rst_gate",  {31'd0, gate_o}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd1);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);

        chk("done_q_empty", done_q.size(), 32'd0);
        chk("err_q_empty", err_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
